// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
//   Beat (W-phase) timing generator for the hardwired controller. It produces
//   a one-hot beat vector W_clk and runs machine cycles of 1, 2 or 3 beats. The
//   controller shortens (SHORT), lengthens (LONG) or ends (STOP) the cycles.
//   A rising edge on the panel start level QD starts a run. A STOP request
//   halts the run at the end of the current machine cycle.
//
// Optional feature (macro SINGLE_STEP_EN):
//   This macro adds the STEP_MODE input. When STEP_MODE is high at the end of a
//   machine cycle, the sequencer returns to idle. Each QD edge then runs exactly
//   one machine cycle. The level is only looked at on the end-of-cycle beat, so
//   a mid-cycle change takes effect at the next end of cycle.
//
// Ports:
//   T_clk_3   in   system clock, rising edge
//   CLR       in   asynchronous active-high reset
//   QD        in   start level, synchronous to T_clk_3
//   SHORT     in   current machine cycle ends after W1
//   LONG      in   current machine cycle extends to W3 (looked at in W2 only)
//   STOP      in   halt at the end of the current machine cycle
//   STEP_MODE in   (SINGLE_STEP_EN only) one machine cycle per QD edge
//   W_clk     out  one-hot beat: W1=001, W2=010, W3=100, idle=000
//   RUNNING   out  high in any beat state
//   CYC_DONE  out  one-clock pulse after each completed machine cycle
//   CYC_CNT   out  completed machine cycles since reset (wraps)
//
// Handshake: there is no valid/ready pair. W_clk is the beat strobe.
// CYC_DONE is valid for exactly one clock, in the clock after the
// end-of-cycle beat.
// -----------------------------------------------------------------------------
module beat_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             T_clk_3,
   input  logic             CLR,
   input  logic             QD,
   input  logic             SHORT,
   input  logic             LONG,
   input  logic             STOP,
`ifdef SINGLE_STEP_EN
   input  logic             STEP_MODE,
`endif
   output logic [2:0]       W_clk,
   output logic             RUNNING,
   output logic             CYC_DONE,
   output logic [CNT_W-1:0] CYC_CNT
);

   // The state encoding is the beat vector itself. W_clk therefore comes
   // straight from flops and is observable state for checkers.
   typedef enum logic [2:0] {
      IDLE = 3'b000,
      W1   = 3'b001,
      W2   = 3'b010,
      W3   = 3'b100
   } state_t;

   state_t state, state_nxt;
   logic   qd_q;
   logic   stop_lat, stop_lat_nxt;
   logic   start;
   logic   eoc;
   logic   halt;

   assign start = QD & ~qd_q;

`ifdef SINGLE_STEP_EN
   assign halt = stop_lat | STOP | STEP_MODE;
`else
   assign halt = stop_lat | STOP;
`endif

   always_comb begin
      state_nxt    = state;
      stop_lat_nxt = stop_lat;
      eoc          = 1'b0;
      case (state)
         IDLE: begin
            stop_lat_nxt = 1'b0;
            if (start) state_nxt = W1;
         end
         W1: begin
            if (SHORT) eoc = 1'b1;
            else       state_nxt = W2;
         end
         W2: begin
            if (LONG) state_nxt = W3;
            else      eoc = 1'b1;
         end
         W3:      eoc = 1'b1;
         default: state_nxt = IDLE;
      endcase
      // A STOP seen on any beat is remembered until the cycle ends. The STOP
      // on the end-of-cycle beat itself acts directly through halt.
      if (state != IDLE) begin
         if (eoc) begin
            stop_lat_nxt = 1'b0;
            state_nxt    = halt ? IDLE : W1;
         end else if (STOP) begin
            stop_lat_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge T_clk_3 or posedge CLR) begin
      if (CLR) begin
         state    <= IDLE;
         qd_q     <= 1'b1;   // QD held high through reset must not start a run
         stop_lat <= 1'b0;
         CYC_DONE <= 1'b0;
         CYC_CNT  <= '0;
      end else begin
         state    <= state_nxt;
         qd_q     <= QD;
         stop_lat <= stop_lat_nxt;
         CYC_DONE <= eoc;
         if (eoc) CYC_CNT <= CYC_CNT + CNT_W'(1);
      end
   end

   assign W_clk   = state;
   assign RUNNING = |state;

endmodule

// File: tb/tb_beat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beat_sequencer
//   Randomized bench for beat_sequencer. Each run is planned as a list of
//   machine-cycle lengths. The driver turns the plan into per-clock controller
//   requests and pushes the expected post-edge outputs into exp_q. A separate
//   monitor pops one entry after every rising edge and compares it.
//   CNT_W is 4 here, so counter wrap happens within a short run.
// -----------------------------------------------------------------------------
module tb_beat_sequencer;

  localparam int CNT_W = 4;
  localparam int EW    = CNT_W + 5;

  // clock / reset block
  logic clk = 1'b0;
  logic clr;
  logic qd, short_r, long_r, stop_r;
  logic step_mode;
  logic [2:0]       w_clk;
  logic             running;
  logic             cyc_done;
  logic [CNT_W-1:0] cyc_cnt;

  always #5 clk = ~clk;

  beat_sequencer #(.CNT_W(CNT_W)) dut (
    .T_clk_3  (clk),
    .CLR      (clr),
    .QD       (qd),
    .SHORT    (short_r),
    .LONG     (long_r),
    .STOP     (stop_r),
`ifdef SINGLE_STEP_EN
    .STEP_MODE(step_mode),
`endif
    .W_clk    (w_clk),
    .RUNNING  (running),
    .CYC_DONE (cyc_done),
    .CYC_CNT  (cyc_cnt)
  );

  // scoreboard state
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] m_cnt;
  int               plan_len[$];
  int               checks   = 0;
  int               failures = 0;

  function automatic logic [EW-1:0] pack(input logic [2:0] w, input logic d,
                                         input logic [CNT_W-1:0] c);
    return {w, |w, d, c};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got w=%b run=%b done=%b cnt=%0d, want w=%b run=%b done=%b cnt=%0d",
               name, act[EW-1 -: 3], act[CNT_W+1], act[CNT_W], act[CNT_W-1:0],
               req[EW-1 -: 3], req[CNT_W+1], req[CNT_W], req[CNT_W-1:0]);
    end
  endtask

  // monitor: one expected entry per rising edge while the queue is non-empty
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("beat", pack(w_clk, cyc_done, cyc_cnt) ^ {3'b000, running ^ (|w_clk), {(CNT_W+1){1'b0}}},
                                  exp_q.pop_front());
    end
  end

  // driver: sets inputs for the coming edge and records what must follow it
  task automatic drive(input logic q, input logic s, input logic l, input logic t,
                       input logic [2:0] w, input logic d);
    @(negedge clk);
    qd = q; short_r = s; long_r = l; stop_r = t;
    exp_q.push_back(pack(w, d, m_cnt));
  endtask

  // Execute plan_len as one run. A STOP is raised on beat stop_beat of the last
  // cycle (0 = none, only used with step mode, which ends the run by itself).
  task automatic run(input int stop_beat, input logic step);
    int n;
    n = plan_len.size();
    step_mode = step;
    drive(1'b1, rnd(), rnd(), rnd(), 3'b001, 1'b0);
    for (int c = 0; c < n; c++) begin
      int  len;
      bit  last;
      len  = plan_len[c];
      last = (c == n - 1);
      for (int b = 1; b <= len; b++) begin
        logic s, l, t, q, d;
        logic [2:0] w;
        s = (b == 1) ? logic'(len == 1) : rnd();
        l = (b == 2) ? logic'(len == 3) : rnd();
        t = 1'b0;
        if (last && stop_beat != 0)
          t = (b == stop_beat) ? 1'b1 : ((b > stop_beat) ? rnd() : 1'b0);
        q = (last && b == len) ? 1'b0 : rnd();
        if (b < len) begin
          w = 3'(1 << b);
          d = 1'b0;
        end else begin
          m_cnt = m_cnt + 1'b1;
          d = 1'b1;
          w = last ? 3'b000 : 3'b001;
        end
        drive(q, s, l, t, w, d);
      end
    end
    repeat (1 + $urandom_range(0, 2)) drive(1'b0, rnd(), rnd(), rnd(), 3'b000, 1'b0);
    step_mode = 1'b0;
  endtask

  initial begin
    clr = 1'b1; qd = 1'b1; short_r = 1'b0; long_r = 1'b0; stop_r = 1'b0;
    step_mode = 1'b0; m_cnt = '0;
    #12;
    check("reset_state", pack(w_clk, cyc_done, cyc_cnt), pack(3'b000, 1'b0, '0));
    @(negedge clk);
    clr = 1'b0;
    // QD held high across reset release must not start a run
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // W1, W2 with STOP in W2: 001, 010, 000
    plan_len = '{2};        run(2, 1'b0);
    // LONG cycle then SHORT+STOP cycle: 001, 010, 100, 001, 000
    plan_len = '{3, 1};     run(1, 1'b0);
    // STOP in W1, LONG in W2: halt deferred to after W3
    plan_len = '{3};        run(1, 1'b0);
    // 17 SHORT cycles: counter wraps through 15 -> 0
    plan_len.delete();
    repeat (17) plan_len.push_back(1);
    run(1, 1'b0);

    // random runs
    repeat (25) begin
      int nc;
      plan_len.delete();
      nc = $urandom_range(1, 4);
      repeat (nc) plan_len.push_back($urandom_range(1, 3));
      run($urandom_range(1, plan_len[nc-1]), 1'b0);
    end

`ifdef SINGLE_STEP_EN
    // single-step: one machine cycle per QD edge, no STOP
    repeat (6) begin
      plan_len = '{$urandom_range(1, 3)};
      run(0, 1'b1);
    end
`endif

    // asynchronous reset in the middle of W2
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0);
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    check("async_clr", pack(w_clk, cyc_done, cyc_cnt), pack(3'b000, 1'b0, '0));
    exp_q.delete();
    m_cnt = '0;
    @(negedge clk);
    qd = 1'b0;
    clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    plan_len = '{2, 1};     run(1, 1'b0);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
